spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//   SPI Mode 0 (CPOL=0, CPHA=0) master: the initiator for the SPI slave bridge endpoints.
//   - Serialises bytes MSB-first onto mosi and deserialises miso, with one byte per handshake.
//   - cs_n stays low across a burst; tx_last on a byte closes the frame.
//   - Sits between the bridge core and off-chip SPI devices; sck is generated from clk.
// PARAMETERS
//   CLK_DIV   4  clk cycles per sck half-period (min 4)
//   CS_SETUP  2  cycles cs_n low, sck low, before the first LOW phase (min 1)
//   CS_HOLD   2  cycles cs_n low after the final sck fall of the frame (min 1)
// PORTS
//   clk       in   1  system clock; single clock domain
//   rst_n     in   1  reset; asynchronous, active-low
//   sck       out  1  SPI clock, idle low
//   mosi      out  1  master data out, changes only while sck low
//   miso      in   1  slave data in, async; 2-FF synchronised internally
//   cs_n      out  1  chip select, active low
//   tx_data   in   8  byte to send
//   tx_last   in   1  byte ends the frame; sampled with tx_data
//   tx_valid  in   1  tx_data/tx_last valid
//   tx_ready  out  1  master can accept a byte
//   rx_data   out  8  last received byte; held until next byte completes
//   rx_valid  out  1  1-cycle pulse: rx_data updated
//   busy      out  1  state != IDLE
// BEHAVIOUR
//   Reset (async):
//   - sck=0, cs_n=1, mosi=0, tx_ready=0, rx_data=0, rx_valid=0, busy=0.
//   - State=IDLE, counters=0. tx_ready rises the first cycle after rst_n deasserts.
//   Handshake: a byte is accepted on a clk edge with tx_valid&tx_ready.
//   - tx_data and tx_last are latched on acceptance.
//   - tx_ready=1 only in IDLE and WAIT. It drops the cycle after acceptance.
//   State machine (all outputs registered):
//   - IDLE: cs_n=1, sck=0, mosi=0. Accept -> SETUP.
//   - SETUP: cs_n=0, sck=0, mosi=bit7; CS_SETUP cycles -> LOW.
//   - LOW: sck=0, mosi=current bit; CLK_DIV cycles -> HIGH.
//   - HIGH: sck=1; CLK_DIV cycles. Synchronised miso is sampled in the last HIGH cycle and shifted in LSB-side.
//     - Bit index >0: decrement, drive next bit, -> LOW.
//     - Bit index =0: byte done, sck=0; rx_data/rx_valid pulse in this same cycle; -> HOLD if latched tx_last, else -> WAIT.
//   - WAIT: cs_n=0, sck=0, mosi holds the last bit; no timeout. Accept -> LOW (mosi=new bit7). There is no second SETUP.
//   - HOLD: cs_n=0, sck=0; CS_HOLD cycles -> GAP.
//   - GAP: cs_n=1; CLK_DIV cycles -> IDLE (minimum cs_n high time).
//   Timing and rules:
//   - Single-byte frame: cs_n low exactly CS_SETUP + 16*CLK_DIV + CS_HOLD cycles, with 8 sck rising edges.
//   - Bytes inside a burst: sck low for >= CLK_DIV+1 cycles between bytes.
//   - Slave miso must be stable >= 2 clk cycles before the end of each HIGH phase.
//   - tx_valid/tx_data changes while tx_ready=0 are ignored.
//   - An rx_valid pulse and a tx handshake in WAIT may occur on consecutive cycles; no byte is lost.
//   - rst_n asserted mid-frame: cs_n goes high and sck low immediately; the partial byte is discarded and rx_valid is not pulsed.
// TESTING
//   1) CLK_DIV=4, CS_SETUP=2, CS_HOLD=2; send 0xA5, tx_last=1, miso looped to mosi
//      -> rx_data=0xA5, one rx_valid pulse, cs_n low 68 cycles, 8 sck rises.
//   2) Slave model returns 0x3C while master sends 0xFF
//      -> rx_data=0x3C; mosi observed 1 on every sck rise.
//   3) Burst 0x01, 0x80, 0x7E (last on third), tx_valid held high
//      -> cs_n low continuously, 24 sck rises, 3 rx_valid pulses, then 4-cycle GAP.
//   4) Burst byte 1 (tx_last=0), then tx_valid held low 50 cycles
//      -> WAIT with cs_n=0, sck=0, busy=1, tx_ready=1; next byte completes normally.
//   5) rst_n pulsed low after 3 sck rises
//      -> cs_n=1, sck=0, mosi=0 asynchronously, no rx_valid; next frame correct.
//   6) Back-to-back single-byte frames
//      -> cs_n high >= CLK_DIV cycles between frames; tx_ready=0 during GAP.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode 0 master: serialises bytes MSB-first on mosi, samples miso on the last cycle of each
// sck high phase, keeps cs_n low across a burst and closes the frame on a byte marked tx_last.
module spi_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       sck,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy
);

   localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_CNT = (MAX_A > CS_HOLD) ? MAX_A : CS_HOLD;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] DIV_END   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(CS_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_LOW, S_HIGH, S_WAIT, S_HOLD, S_GAP
   } state_e;

   // tx_valid/tx_ready: a byte moves on any clk edge where both are high; tx_data and
   // tx_last are captured on that edge and tx_ready is low from the next cycle on.
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       tx_sh_q, tx_sh_d;
   logic [7:0]       rx_sh_q, rx_sh_d;
   logic             last_q, last_d;
   logic             miso_meta_q, miso_sync_q;
   logic             sck_q, sck_d;
   logic             mosi_q, mosi_d;
   logic             cs_n_q, cs_n_d;
   logic             tx_ready_q, tx_ready_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             busy_q, busy_d;
   logic             accept;

   assign accept = tx_valid & tx_ready_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      bit_d      = bit_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      last_d     = last_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      case (state_q)
         S_IDLE, S_WAIT: begin
            cnt_d = '0;
            if (accept) begin
               tx_sh_d = tx_data;
               last_d  = tx_last;
               bit_d   = 3'd7;
               // Inside a burst the chip select is already set up, so go straight to LOW.
               state_d = (state_q == S_IDLE) ? S_SETUP : S_LOW;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_END) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end
         end
         S_LOW: begin
            if (cnt_q == DIV_END) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end
         end
         S_HIGH: begin
            if (cnt_q == DIV_END) begin
               cnt_d   = '0;
               rx_sh_d = {rx_sh_q[6:0], miso_sync_q};
               if (bit_q != 3'd0) begin
                  bit_d   = bit_q - 3'd1;
                  tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  state_d = S_LOW;
               end else begin
                  rx_data_d  = {rx_sh_q[6:0], miso_sync_q};
                  rx_valid_d = 1'b1;
                  state_d    = last_q ? S_HOLD : S_WAIT;
               end
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_END) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (cnt_q == DIV_END) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so each pin lines up with state_q.
   always_comb begin
      sck_d      = (state_d == S_HIGH);
      cs_n_d     = (state_d == S_IDLE) || (state_d == S_GAP);
      mosi_d     = (state_d == S_IDLE || state_d == S_GAP) ? 1'b0 : tx_sh_d[7];
      tx_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         last_q      <= 1'b0;
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
         sck_q       <= 1'b0;
         mosi_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         tx_ready_q  <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         last_q      <= last_d;
         miso_meta_q <= miso;
         miso_sync_q <= miso_meta_q;
         sck_q       <= sck_d;
         mosi_q      <= mosi_d;
         cs_n_q      <= cs_n_d;
         tx_ready_q  <= tx_ready_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign sck      = sck_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;
   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and pattern slave, bursts, WAIT idling,
// mid-frame reset and back-to-back frames, checked against an expected-byte queue.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sck, mosi, miso, cs_n;
   logic [7:0] tx_data;
   logic       tx_last, tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [8:0] tx_q[$];

   // slave model: loopback or a fixed pattern shifted out MSB-first, advancing on sck fall
   logic       slave_loop;
   logic [7:0] slave_pat;
   logic [2:0] slave_idx = '0;

   int sck_rises = 0, mosi_ones = 0, cs_low = 0, rx_pulses = 0, cs_rises = 0;

   spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n),
      .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   assign miso = slave_loop ? mosi : slave_pat[3'd7 - slave_idx];

   always @(negedge sck or posedge cs_n) begin
      if (cs_n) slave_idx <= '0;
      else      slave_idx <= slave_idx + 3'd1;
   end

   always @(posedge sck) begin
      sck_rises <= sck_rises + 1;
      if (mosi === 1'b1) mosi_ones <= mosi_ones + 1;
   end

   always @(posedge cs_n) cs_rises <= cs_rises + 1;

   // values seen here belong to the clk cycle that just ended
   always @(posedge clk) begin
      if (cs_n === 1'b0)    cs_low    <= cs_low + 1;
      if (rx_valid === 1'b1) rx_pulses <= rx_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives tx_q with tx_valid held high until it empties; pops exp_q on each rx_valid.
   task automatic xfer(input int n_rx, input int budget);
      int  got = 0;
      logic sent;
      for (int c = 0; c < budget && got < n_rx; c++) begin
         if (tx_q.size() > 0) begin
            tx_valid = 1'b1;
            tx_data  = tx_q[0][7:0];
            tx_last  = tx_q[0][8];
         end else begin
            tx_valid = 1'b0;
         end
         sent = tx_valid & tx_ready;
         @(negedge clk);
         if (sent) void'(tx_q.pop_front());
         if (rx_valid) begin
            if (exp_q.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
            else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            got++;
         end
      end
      tx_valid = 1'b0;
      check("rx_count", got, n_rx);
   endtask

   // Waits for IDLE; gap counts cycles with cs_n high while tx_ready is low.
   task automatic wait_idle(output int gap);
      int done = 0;
      gap = 0;
      for (int c = 0; c < 200 && done == 0; c++) begin
         if (tx_ready === 1'b1 && cs_n === 1'b1) done = 1;
         else begin
            if (cs_n === 1'b1 && tx_ready === 1'b0) gap++;
            @(negedge clk);
         end
      end
      check("idle_reached", done, 1);
   endtask

   initial begin
      int gap, b_sck, b_ones, b_low, b_rx, b_csr, waitbad, reached;
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
      slave_loop = 1'b1; slave_pat = '0;
      repeat (3) @(negedge clk);
      check("rst_sck", sck, 0);
      check("rst_cs_n", cs_n, 1);
      check("rst_mosi", mosi, 0);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("tx_ready_after_rst", tx_ready, 1);

      // single byte, loopback
      b_sck = sck_rises; b_low = cs_low; b_rx = rx_pulses;
      tx_q.push_back({1'b1, 8'hA5}); exp_q.push_back(8'hA5);
      xfer(1, 400);
      wait_idle(gap);
      check("t1_sck_rises", sck_rises - b_sck, 8);
      check("t1_cs_low", cs_low - b_low, 68);
      check("t1_rx_pulses", rx_pulses - b_rx, 1);
      check("t1_gap", gap, 4);

      // pattern slave 0x3C while master sends 0xFF
      slave_loop = 1'b0; slave_pat = 8'h3C;
      b_sck = sck_rises; b_ones = mosi_ones;
      tx_q.push_back({1'b1, 8'hFF}); exp_q.push_back(8'h3C);
      xfer(1, 400);
      wait_idle(gap);
      check("t2_sck_rises", sck_rises - b_sck, 8);
      check("t2_mosi_ones", mosi_ones - b_ones, 8);
      slave_loop = 1'b1;

      // three-byte burst with tx_valid held high
      b_sck = sck_rises; b_rx = rx_pulses; b_csr = cs_rises;
      tx_q.push_back({1'b0, 8'h01}); exp_q.push_back(8'h01);
      tx_q.push_back({1'b0, 8'h80}); exp_q.push_back(8'h80);
      tx_q.push_back({1'b1, 8'h7E}); exp_q.push_back(8'h7E);
      xfer(3, 600);
      check("t3_cs_continuous", cs_rises - b_csr, 0);
      wait_idle(gap);
      check("t3_sck_rises", sck_rises - b_sck, 24);
      check("t3_rx_pulses", rx_pulses - b_rx, 3);
      check("t3_gap", gap, 4);

      // first byte of a burst, then 50 idle cycles in WAIT
      tx_q.push_back({1'b0, 8'h11}); exp_q.push_back(8'h11);
      xfer(1, 400);
      waitbad = 0;
      for (int c = 0; c < 50; c++) begin
         if (!(cs_n === 1'b0 && sck === 1'b0 && busy === 1'b1 && tx_ready === 1'b1)) waitbad++;
         @(negedge clk);
      end
      check("t4_wait_state", waitbad, 0);
      check("t4_wait_ready", tx_ready, 1);
      tx_q.push_back({1'b1, 8'hE7}); exp_q.push_back(8'hE7);
      xfer(1, 400);
      wait_idle(gap);
      check("t4_gap", gap, 4);

      // reset mid-frame after three sck rises
      b_sck = sck_rises;
      tx_q.push_back({1'b1, 8'h5A});
      reached = 0;
      for (int c = 0; c < 400 && reached == 0; c++) begin
         if (tx_q.size() > 0) begin
            tx_valid = 1'b1; tx_data = tx_q[0][7:0]; tx_last = tx_q[0][8];
            if (tx_ready) begin
               @(negedge clk);
               void'(tx_q.pop_front());
               tx_valid = 1'b0;
            end else @(negedge clk);
         end else begin
            if (sck_rises - b_sck >= 3) reached = 1;
            else @(negedge clk);
         end
      end
      tx_valid = 1'b0;
      check("t5_three_rises", reached, 1);
      b_rx = rx_pulses;
      #2 rst_n = 1'b0;
      #1;
      check("t5_cs_n_async", cs_n, 1);
      check("t5_sck_async", sck, 0);
      check("t5_mosi_async", mosi, 0);
      check("t5_busy_async", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_no_rx_valid", rx_pulses - b_rx, 0);
      check("t5_rx_data_cleared", rx_data, 0);
      tx_q.push_back({1'b1, 8'hC3}); exp_q.push_back(8'hC3);
      xfer(1, 400);
      wait_idle(gap);

      // back-to-back single-byte frames; second byte presented while busy
      b_csr = cs_rises;
      tx_q.push_back({1'b1, 8'h96}); exp_q.push_back(8'h96);
      tx_q.push_back({1'b1, 8'h69}); exp_q.push_back(8'h69);
      xfer(1, 400);
      wait_idle(gap);
      check("t6_gap", gap, 4);
      xfer(1, 400);
      wait_idle(gap);
      check("t6_two_frames", cs_rises - b_csr, 2);
      check("t6_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
